regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised multi-port register file for the pipelined CPU datapath: one synchronous write port, two combinational read ports, a hardwired zero register, optional write-to-read bypass, and a per-register busy scoreboard. It sits between decode, which reads operands and allocates the destination, and writeback, which writes results and clears busy. It replaces the fixed 32-bit single-register storage element and generalises it in width, depth and hazard tracking.

## Interface
Parameters:
- WIDTH, 64: data width of each register.
- DEPTH, 32: number of registers, 2..256.
- ZERO_REG, DEPTH-1: index hardwired to zero. Reads return 0, writes are ignored, and it is never busy.
- BYPASS, 1: if 1, a same-cycle write is forwarded to the read ports and busy outputs.
- AW, $clog2(DEPTH): address width (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all registers and busy bits immediately.
- wr_en  in  1  write strobe (writeback).
- wr_addr  in  AW  write index.
- wr_data  in  WIDTH  write value.
- rd_addr1, rd_addr2  in  AW  read indices.
- rd_data1, rd_data2  out  WIDTH  read values (combinational).
- alloc_en  in  1  mark destination busy (decode issue).
- alloc_addr  in  AW  index to mark busy.
- busy1, busy2  out  1  busy status of rd_addr1 / rd_addr2 (combinational).
- busy_vec  out  DEPTH  busy bit of every register, bit i = register i.

## Operation
- Storage: DEPTH x WIDTH flops, ZERO_REG excluded or held at 0. Busy: DEPTH flops.
- Write: on posedge, if wr_en and wr_addr != ZERO_REG and wr_addr < DEPTH, then reg[wr_addr] <= wr_data and busy[wr_addr] <= 0.
- Alloc: on posedge, if alloc_en and alloc_addr != ZERO_REG and alloc_addr < DEPTH, then busy[alloc_addr] <= 1.
- Alloc and write to the same address in the same cycle: data is written and alloc wins, so busy ends at 1 because a newer producer has been issued.
- Read: rd_dataN = 0 if rd_addrN == ZERO_REG or rd_addrN >= DEPTH. Otherwise:
  - BYPASS=1 and wr_en and wr_addr == rd_addrN: rd_dataN = wr_data.
  - Otherwise: rd_dataN = reg[rd_addrN].
- Busy: busyN = busy_vec[rd_addrN]. With BYPASS=1 and a same-cycle write to rd_addrN, busyN = 0. Busy is 0 for ZERO_REG and out-of-range addresses. busy_vec is the raw flop state with no bypass.
- Both read ports are independent. Identical addresses on both ports return identical data.
- Out-of-range writes and allocs are silently dropped, with no state change.

## Timing
- Reset is asynchronous. While reset=1:
  - all registers are 0 and busy_vec is 0;
  - rd_data1/2 are 0 and busy1/2 are 0 regardless of inputs;
  - writes and allocs are ignored.
- Reset deassertion: the first edge with reset=0 performs normal writes and allocs.
- Reset asserted mid-operation clears everything within the same cycle, without waiting for an edge. Busy state and pending data are lost.
- Write latency:
  - BYPASS=0: data is visible on a read port one cycle after the wr_en edge.
  - BYPASS=1: data is visible in the same cycle wr_en is asserted.
- Alloc latency: busy is visible on busyN and busy_vec the cycle after the alloc edge.
- Busy clear: busy_vec clears the cycle after the write edge. busyN clears in the same cycle if BYPASS=1.
- No combinational path from alloc_en or alloc_addr to any output.

## Test plan
- Reset: preload reg 3 with 0xDEAD, then assert reset asynchronously between edges. rd_addr1=3 gives rd_data1=0 and busy_vec=0 before the next posedge.
- Write/read with BYPASS=0: write reg 5 = 0x1234_5678_9ABC_DEF0. The same-cycle read of 5 returns the old value 0; the next cycle returns 0x1234_5678_9ABC_DEF0 on both ports.
- Bypass with BYPASS=1: wr_en, wr_addr=7, wr_data=0x55 and rd_addr2=7 in the same cycle give rd_data2=0x55 immediately.
- Zero register: write 0xFF to 31 (DEPTH=32), then read 31 on both ports. Both return 0. alloc 31 leaves busy_vec[31]=0.
- Scoreboard:
  - alloc 4 gives busy_vec[4]=1 next cycle and busy1=1 with rd_addr1=4.
  - Writing 4 with 0x9 clears busy_vec[4] next cycle.
  - Simultaneous alloc 4 and write 4 leave busy_vec[4]=1 with reg 4 updated.
- Parametrisation: WIDTH=32, DEPTH=20 (AW=5). Writing address 25 is dropped, and reading 25 returns 0 with busy 0. Random write/read of all 20 registers matches a reference model.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with a hardwired zero register, optional write-to-read
// forwarding and a per-register busy scoreboard for decode/writeback hazard tracking.
module regfile_scoreboard #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = DEPTH - 1,
    parameter int BYPASS   = 1,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr1,
    input  logic [AW-1:0]    rd_addr2,
    output logic [WIDTH-1:0] rd_data1,
    output logic [WIDTH-1:0] rd_data2,
    input  logic             alloc_en,
    input  logic [AW-1:0]    alloc_addr,
    output logic             busy1,
    output logic             busy2,
    output logic [DEPTH-1:0] busy_vec
);

    // One extra bit so DEPTH itself is representable for the range check.
    localparam logic [AW:0] ZERO_IDX  = (AW+1)'(ZERO_REG);
    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_wr_hit;
    logic [DEPTH-1:0] w_alloc_hit;
    logic             w_wr_ok;
    logic             w_alloc_ok;

    assign w_wr_ok    = wr_en && ({1'b0, wr_addr} != ZERO_IDX)
                              && ({1'b0, wr_addr} < DEPTH_LIM);
    assign w_alloc_ok = alloc_en && ({1'b0, alloc_addr} != ZERO_IDX)
                                 && ({1'b0, alloc_addr} < DEPTH_LIM);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_dec
            assign w_wr_hit[gi]    = w_wr_ok    && (wr_addr    == AW'(gi));
            assign w_alloc_hit[gi] = w_alloc_ok && (alloc_addr == AW'(gi));
        end
    endgenerate

    // Alloc wins over a same-cycle write: a newer producer has been issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr_hit[i]) begin
                    r_regs[i] <= wr_data;
                end
            end
            r_busy <= w_alloc_hit | (r_busy & ~w_wr_hit);
        end
    end

    logic [AW-1:0]    w_rd_addr [2];
    logic [WIDTH-1:0] w_rd_data [2];
    logic             w_rd_busy [2];

    assign w_rd_addr[0] = rd_addr1;
    assign w_rd_addr[1] = rd_addr2;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic w_ok;
            logic w_fwd;
            assign w_ok  = !reset && ({1'b0, w_rd_addr[gi]} != ZERO_IDX)
                                  && ({1'b0, w_rd_addr[gi]} < DEPTH_LIM);
            assign w_fwd = (BYPASS != 0) && w_wr_ok && (wr_addr == w_rd_addr[gi]);
            assign w_rd_data[gi] = !w_ok ? '0 :
                                   w_fwd ? wr_data : r_regs[w_rd_addr[gi]];
            assign w_rd_busy[gi] = w_ok && !w_fwd && r_busy[w_rd_addr[gi]];
        end
    endgenerate

    assign rd_data1 = w_rd_data[0];
    assign rd_data2 = w_rd_data[1];
    assign busy1    = w_rd_busy[0];
    assign busy2    = w_rd_busy[1];
    assign busy_vec = r_busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: bypass, non-bypass and a WIDTH=32/DEPTH=20 build.
module tb_regfile_scoreboard;

    logic clk;
    logic reset;

    // Default build: WIDTH=64, DEPTH=32, ZERO_REG=31, BYPASS=1
    logic        b_wr_en, b_alloc_en;
    logic [4:0]  b_wr_addr, b_rd_addr1, b_rd_addr2, b_alloc_addr;
    logic [63:0] b_wr_data, b_rd_data1, b_rd_data2;
    logic        b_busy1, b_busy2;
    logic [31:0] b_busy_vec;

    // BYPASS=0 build
    logic        n_wr_en, n_alloc_en;
    logic [4:0]  n_wr_addr, n_rd_addr1, n_rd_addr2, n_alloc_addr;
    logic [63:0] n_wr_data, n_rd_data1, n_rd_data2;
    logic        n_busy1, n_busy2;
    logic [31:0] n_busy_vec;

    // WIDTH=32, DEPTH=20 build (ZERO_REG=19)
    logic        p_wr_en, p_alloc_en;
    logic [4:0]  p_wr_addr, p_rd_addr1, p_rd_addr2, p_alloc_addr;
    logic [31:0] p_wr_data, p_rd_data1, p_rd_data2;
    logic        p_busy1, p_busy2;
    logic [19:0] p_busy_vec;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [20];

    regfile_scoreboard u_byp (
        .clk(clk), .reset(reset),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .rd_addr1(b_rd_addr1), .rd_addr2(b_rd_addr2),
        .rd_data1(b_rd_data1), .rd_data2(b_rd_data2),
        .alloc_en(b_alloc_en), .alloc_addr(b_alloc_addr),
        .busy1(b_busy1), .busy2(b_busy2), .busy_vec(b_busy_vec)
    );

    regfile_scoreboard #(.BYPASS(0)) u_nb (
        .clk(clk), .reset(reset),
        .wr_en(n_wr_en), .wr_addr(n_wr_addr), .wr_data(n_wr_data),
        .rd_addr1(n_rd_addr1), .rd_addr2(n_rd_addr2),
        .rd_data1(n_rd_data1), .rd_data2(n_rd_data2),
        .alloc_en(n_alloc_en), .alloc_addr(n_alloc_addr),
        .busy1(n_busy1), .busy2(n_busy2), .busy_vec(n_busy_vec)
    );

    regfile_scoreboard #(.WIDTH(32), .DEPTH(20)) u_par (
        .clk(clk), .reset(reset),
        .wr_en(p_wr_en), .wr_addr(p_wr_addr), .wr_data(p_wr_data),
        .rd_addr1(p_rd_addr1), .rd_addr2(p_rd_addr2),
        .rd_data1(p_rd_data1), .rd_data2(p_rd_data2),
        .alloc_en(p_alloc_en), .alloc_addr(p_alloc_addr),
        .busy1(p_busy1), .busy2(p_busy2), .busy_vec(p_busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        b_wr_en = 0; b_alloc_en = 0;
        n_wr_en = 0; n_alloc_en = 0;
        p_wr_en = 0; p_alloc_en = 0;
    endtask

    initial begin
        reset = 1;
        idle();
        b_wr_addr = 0; b_wr_data = 0; b_rd_addr1 = 0; b_rd_addr2 = 0; b_alloc_addr = 0;
        n_wr_addr = 0; n_wr_data = 0; n_rd_addr1 = 0; n_rd_addr2 = 0; n_alloc_addr = 0;
        p_wr_addr = 0; p_wr_data = 0; p_rd_addr1 = 0; p_rd_addr2 = 0; p_alloc_addr = 0;
        #1;
        chk("reset_rd_data1", b_rd_data1, 64'd0);
        chk("reset_busy_vec", b_busy_vec, 64'd0);

        // Writes and allocs under reset are ignored; no forwarding either.
        b_wr_en = 1; b_wr_addr = 3; b_wr_data = 64'h77; b_rd_addr1 = 3;
        b_alloc_en = 1; b_alloc_addr = 8;
        #1;
        chk("reset_no_fwd", b_rd_data1, 64'd0);
        tick();
        idle();
        reset = 0;
        #1;
        chk("reset_write_ignored", b_rd_data1, 64'd0);
        chk("reset_alloc_ignored", b_busy_vec, 64'd0);

        // Preload reg 3 and mark 6 busy, then assert reset between edges.
        b_wr_en = 1; b_wr_addr = 3; b_wr_data = 64'hDEAD; b_rd_addr1 = 3;
        b_alloc_en = 1; b_alloc_addr = 6; b_rd_addr2 = 6;
        #1;
        chk("bypass_same_cycle_3", b_rd_data1, 64'hDEAD);
        tick();
        idle();
        #1;
        chk("preload_rd3", b_rd_data1, 64'hDEAD);
        chk("preload_busy_vec", b_busy_vec, 64'h40);
        chk("preload_busy2", b_busy2, 64'd1);
        #2 reset = 1;
        #1;
        chk("async_reset_rd3", b_rd_data1, 64'd0);
        chk("async_reset_busy_vec", b_busy_vec, 64'd0);
        chk("async_reset_busy2", b_busy2, 64'd0);
        tick();
        reset = 0;
        #1;
        chk("post_reset_rd3", b_rd_data1, 64'd0);

        // Zero register: writes ignored, never forwarded, never busy.
        b_wr_en = 1; b_wr_addr = 31; b_wr_data = 64'hFF;
        b_rd_addr1 = 31; b_rd_addr2 = 31;
        b_alloc_en = 1; b_alloc_addr = 31;
        #1;
        chk("zero_same_rd1", b_rd_data1, 64'd0);
        chk("zero_same_rd2", b_rd_data2, 64'd0);
        tick();
        idle();
        #1;
        chk("zero_rd1", b_rd_data1, 64'd0);
        chk("zero_rd2", b_rd_data2, 64'd0);
        chk("zero_busy_vec", b_busy_vec, 64'd0);
        chk("zero_busy1", b_busy1, 64'd0);

        // Busy bypass on reg 7: allocate, then a write clears busy2 in the same cycle.
        b_alloc_en = 1; b_alloc_addr = 7; b_rd_addr2 = 7;
        #1;
        chk("alloc_no_comb_busy2", b_busy2, 64'd0);
        tick();
        idle();
        #1;
        chk("alloc7_busy2", b_busy2, 64'd1);
        b_wr_en = 1; b_wr_addr = 7; b_wr_data = 64'h55;
        #1;
        chk("bypass_rd2", b_rd_data2, 64'h55);
        chk("bypass_busy2", b_busy2, 64'd0);
        chk("bypass_busy_vec_raw", b_busy_vec, 64'h80);
        tick();
        idle();
        #1;
        chk("write7_busy_vec", b_busy_vec, 64'd0);
        chk("write7_rd2", b_rd_data2, 64'h55);

        // Scoreboard on reg 4.
        b_alloc_en = 1; b_alloc_addr = 4; b_rd_addr1 = 4;
        tick();
        idle();
        #1;
        chk("alloc4_busy_vec", b_busy_vec, 64'h10);
        chk("alloc4_busy1", b_busy1, 64'd1);
        b_wr_en = 1; b_wr_addr = 4; b_wr_data = 64'h9;
        tick();
        idle();
        #1;
        chk("write4_busy_vec", b_busy_vec, 64'd0);
        chk("write4_rd1", b_rd_data1, 64'h9);
        b_wr_en = 1; b_wr_addr = 4; b_wr_data = 64'hA;
        b_alloc_en = 1; b_alloc_addr = 4;
        tick();
        idle();
        #1;
        chk("alloc_wins_busy_vec", b_busy_vec, 64'h10);
        chk("alloc_wins_busy1", b_busy1, 64'd1);
        chk("alloc_wins_rd1", b_rd_data1, 64'hA);

        // Non-bypass build: write reg 5, visible only after the edge.
        n_wr_en = 1; n_wr_addr = 5; n_wr_data = 64'h1234_5678_9ABC_DEF0;
        n_rd_addr1 = 5; n_rd_addr2 = 5;
        #1;
        chk("nb_same_cycle_rd1", n_rd_data1, 64'd0);
        chk("nb_same_cycle_rd2", n_rd_data2, 64'd0);
        tick();
        idle();
        #1;
        chk("nb_next_rd1", n_rd_data1, 64'h1234_5678_9ABC_DEF0);
        chk("nb_next_rd2", n_rd_data2, 64'h1234_5678_9ABC_DEF0);
        n_alloc_en = 1; n_alloc_addr = 5;
        tick();
        idle();
        n_wr_en = 1; n_wr_addr = 5; n_wr_data = 64'h42;
        #1;
        chk("nb_busy1_held", n_busy1, 64'd1);
        chk("nb_rd1_old", n_rd_data1, 64'h1234_5678_9ABC_DEF0);
        tick();
        idle();
        #1;
        chk("nb_busy1_cleared", n_busy1, 64'd0);
        chk("nb_rd1_new", n_rd_data1, 64'h42);

        // Parametrised build: out-of-range address 25 is dropped and reads as 0.
        p_wr_en = 1; p_wr_addr = 25; p_wr_data = 32'hCAFE;
        p_alloc_en = 1; p_alloc_addr = 25;
        p_rd_addr1 = 25; p_rd_addr2 = 25;
        #1;
        chk("par_oor_rd1", p_rd_data1, 64'd0);
        chk("par_oor_busy1", p_busy1, 64'd0);
        tick();
        idle();
        #1;
        chk("par_oor_rd2", p_rd_data2, 64'd0);
        chk("par_oor_busy_vec", p_busy_vec, 64'd0);

        for (int i = 0; i < 20; i++) begin
            p_wr_en = 1; p_wr_addr = 5'(i); p_wr_data = $urandom;
            model[i] = (i == 19) ? 32'd0 : p_wr_data;
            tick();
        end
        idle();
        for (int i = 0; i < 20; i++) begin
            p_rd_addr1 = 5'(i); p_rd_addr2 = 5'(19 - i);
            #1;
            chk($sformatf("par_rd1_%0d", i), p_rd_data1, model[i]);
            chk($sformatf("par_rd2_%0d", 19 - i), p_rd_data2, model[19 - i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
